vga_timing_stream: RTL and testbench



---
 rtl/vga_timing_stream.sv | 140 ++++++++++++++
 tb/tb_vga_timing_stream.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_stream.sv
// vga_timing_stream: VGA raster driven from a valid/ready RGB pixel stream, held idle until PLL lock is stable,
// blanking the remainder of a frame on stream errors and resyncing on the next start-of-packet.
module vga_timing_stream #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_CYCLES = 1024,
  parameter int COLOR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic [3*COLOR_W-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_sop,
  output logic                 in_ready,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic                 frame_start,
  output logic                 underflow
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int PW = 3 * COLOR_W;
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_ON      = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_OFF     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_ON      = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_OFF     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_LOCK, SYNC, RUN} state_t;

  state_t        state_q, state_d;
  logic          lock_meta_q, lock_q;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          pend_valid_q, pend_valid_d;
  logic [PW-1:0] pend_data_q, pend_data_d;
  logic [PW-1:0] rgb_q, rgb_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, fs_q, fs_d, uf_q, uf_d;
  logic          active, first, last, h_end, v_end, acc, err, start, running;

  assign active  = h_q < H_ACT && v_q < V_ACT;
  assign first   = h_q == '0 && v_q == '0;
  assign last    = h_q == H_ACT_LAST && v_q == V_ACT_LAST;
  assign h_end   = h_q == H_LAST;
  assign v_end   = v_q == V_LAST;
  assign running = lock_q && state_q != WAIT_LOCK;
  assign acc     = in_valid && in_ready;
  // missing beat or a premature sop at a live pixel both abandon the frame
  assign err     = state_q == RUN && active && !first && (!in_valid || in_sop);
  assign start   = state_q == SYNC && first && pend_valid_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= WAIT_LOCK;
    else     state_q <= state_d;

  always_comb
    state_d = !lock_q                ? WAIT_LOCK
            : state_q == WAIT_LOCK   ? (lock_cnt_q == LOCK_LAST ? SYNC : WAIT_LOCK)
            : state_q == SYNC        ? (start ? RUN : SYNC)
            : (err || last)          ? SYNC
            :                          RUN;

  always_comb
    in_ready = state_q == SYNC ? !pend_valid_q
             : state_q == RUN  ? active && !first
             :                   1'b0;

  always_comb begin
    lock_cnt_d   = lock_q && state_q == WAIT_LOCK ? lock_cnt_q + 1'b1 : '0;
    h_d          = !running || h_end ? '0 : h_q + 1'b1;
    v_d          = !running ? '0 : !h_end ? v_q : v_end ? '0 : v_q + 1'b1;
    pend_valid_d = !lock_q ? 1'b0 : acc && in_sop ? 1'b1 : state_q == SYNC && first ? 1'b0 : pend_valid_q;
    pend_data_d  = acc && in_sop ? in_data : pend_data_q;
    rgb_d        = !running ? '0 : start ? pend_data_q : state_q == RUN && acc && !in_sop ? in_data : '0;
    hs_d         = !(running && h_q >= HS_ON && h_q < HS_OFF);
    vs_d         = !(running && v_q >= VS_ON && v_q < VS_OFF);
    blank_n_d    = running && active;
    fs_d         = running && first;
    uf_d         = lock_q && err;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lock_meta_q  <= 1'b0;
      lock_q       <= 1'b0;
      lock_cnt_q   <= '0;
      h_q          <= '0;
      v_q          <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      rgb_q        <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      blank_n_q    <= 1'b0;
      fs_q         <= 1'b0;
      uf_q         <= 1'b0;
    end else begin
      lock_meta_q  <= pll_locked;
      lock_q       <= lock_meta_q;
      lock_cnt_q   <= lock_cnt_d;
      h_q          <= h_d;
      v_q          <= v_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      blank_n_q    <= blank_n_d;
      fs_q         <= fs_d;
      uf_q         <= uf_d;
    end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
endmodule

// File: tb/tb_vga_timing_stream.sv
// tb_vga_timing_stream: scaled-down raster bench for vga_timing_stream; expected pixels are queued as
// stimulus is driven and popped as active pixels appear on the pins.
module tb_vga_timing_stream;
  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int LC = 16;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int NPIX = HA * VA;
  localparam int FRAME = HT * VT;
  localparam logic [29:0] RST_PINS = {24'h0, 6'b110000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pll_locked = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_ready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, frame_start, underflow;
  logic [29:0] pins;
  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] sb_q[$];

  assign pins = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start, underflow, in_ready};

  always #5 clk = ~clk;

  vga_timing_stream #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .LOCK_CYCLES(LC), .COLOR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_ready(in_ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .frame_start(frame_start), .underflow(underflow)
  );

  task automatic send_beats(input logic [23:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      int  t;
      bit  acc;
      in_data  = base + 24'(i);
      in_sop   = (i == 0);
      in_valid = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 2 * FRAME) begin
        @(negedge clk);
        acc = in_ready;
        t++;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        vectors++; miscompares++;
        $display("FAIL beat_accept base=%h beat=%0d got in_ready=0 want 1", base, i);
        break;
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic push_ramp(input logic [23:0] base, input int n_ramp, input int n_total);
    for (int i = 0; i < n_total; i++) sb_q.push_back(i < n_ramp ? base + 24'(i) : 24'h0);
  endtask

  task automatic wait_vblank();
    int t = 0;
    do begin @(negedge clk); t++; end while (vga_vs !== 1'b0 && t < 3 * FRAME);
    if (vga_vs !== 1'b0) begin
      vectors++; miscompares++;
      $display("FAIL vblank_wait vs=%b want 0", vga_vs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (pins !== RST_PINS) begin miscompares++; $display("FAIL reset_pins got %b want %b", pins, RST_PINS); end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (pins !== RST_PINS) begin miscompares++; $display("FAIL unlocked_pins got %b want %b", pins, RST_PINS); end
  endtask

  task automatic test_lock_filter();
    int  n;
    bit  got;
    @(posedge clk);
    #1 pll_locked = 1'b1;
    repeat (8) @(posedge clk);
    #1 pll_locked = 1'b0;
    @(posedge clk);
    #1 pll_locked = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 4 * LC) begin
      @(posedge clk); n++;
      @(negedge clk); got = in_ready;
    end
    vectors++;
    if (!got || n != LC + 2) begin miscompares++; $display("FAIL lock_latency got %0d cycles want %0d", n, LC + 2); end
    @(negedge clk);
    vectors++;
    if ({frame_start, vga_blank_n} !== 2'b11) begin
      miscompares++;
      $display("FAIL first_pixel_pins got fs=%b blank_n=%b want 1 1", frame_start, vga_blank_n);
    end
  endtask

  task automatic test_raster();
    int t, hs_n, vs_n, bl_n, nz_n, fs_n, hs_at, vs_at;
    t = 0;
    do begin @(negedge clk); t++; end while (frame_start !== 1'b1 && t < 3 * FRAME);
    hs_n = 0; vs_n = 0; bl_n = 0; nz_n = 0; fs_n = 0; hs_at = -1; vs_at = -1;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if (!vga_hs) begin hs_n++; if (hs_at < 0) hs_at = k; end
      if (!vga_vs) begin vs_n++; if (vs_at < 0) vs_at = k; end
      if (vga_blank_n) bl_n++;
      if (frame_start) fs_n++;
      if ({vga_r, vga_g, vga_b} != 24'h0) nz_n++;
    end
    vectors++; if (hs_n !== VT * HSW) begin miscompares++; $display("FAIL hs_low_count got %0d want %0d", hs_n, VT * HSW); end
    vectors++; if (hs_at !== HA + HFP) begin miscompares++; $display("FAIL hs_start got %0d want %0d", hs_at, HA + HFP); end
    vectors++; if (vs_n !== HT * VSW) begin miscompares++; $display("FAIL vs_low_count got %0d want %0d", vs_n, HT * VSW); end
    vectors++; if (vs_at !== (VA + VFP) * HT) begin miscompares++; $display("FAIL vs_start got %0d want %0d", vs_at, (VA + VFP) * HT); end
    vectors++; if (bl_n !== NPIX) begin miscompares++; $display("FAIL blank_n_count got %0d want %0d", bl_n, NPIX); end
    vectors++; if (nz_n !== 0) begin miscompares++; $display("FAIL idle_rgb_nonzero got %0d want 0", nz_n); end
    vectors++; if (fs_n !== 1) begin miscompares++; $display("FAIL idle_frame_start got %0d want 1", fs_n); end
  endtask

  task automatic test_full_frame();
    int uf_n, fs_n;
    wait_vblank();
    push_ramp(24'h100000, NPIX, NPIX);
    push_ramp(24'h200000, NPIX, NPIX);
    uf_n = 0; fs_n = 0;
    fork
      begin send_beats(24'h100000, NPIX); send_beats(24'h200000, NPIX); end
      begin
        bit on; int t, idx; logic [23:0] want;
        on = 1'b0; t = 0; idx = 0;
        while (sb_q.size() > 0 && t < 4 * FRAME) begin
          @(negedge clk); t++;
          if (frame_start) begin on = 1'b1; fs_n++; end
          if (underflow) uf_n++;
          if (on && vga_blank_n) begin
            want = sb_q.pop_front(); vectors++;
            if ({vga_r, vga_g, vga_b} !== want) begin miscompares++; $display("FAIL full_frame_pixel %0d got %h want %h", idx, {vga_r, vga_g, vga_b}, want); end
            idx++;
          end
        end
        if (sb_q.size() > 0) begin vectors++; miscompares++; $display("FAIL full_frame_drain got %0d left want 0", sb_q.size()); sb_q.delete(); end
      end
    join
    vectors++; if (uf_n !== 0) begin miscompares++; $display("FAIL full_frame_underflow got %0d want 0", uf_n); end
    vectors++; if (fs_n !== 2) begin miscompares++; $display("FAIL full_frame_starts got %0d want 2", fs_n); end
  endtask

  task automatic test_underflow();
    int uf_n, fs_n, uf_at;
    localparam int K = HA + 3;
    wait_vblank();
    push_ramp(24'h300000, K, NPIX);
    push_ramp(24'h400000, NPIX, NPIX);
    uf_n = 0; fs_n = 0; uf_at = -1;
    fork
      begin
        int t;
        send_beats(24'h300000, K);
        t = 0;
        do begin @(negedge clk); t++; end while (!in_ready && t < 2 * FRAME);
        @(posedge clk);
        #1;
        send_beats(24'h400000, NPIX);
      end
      begin
        bit on; int t, idx; logic [23:0] want;
        on = 1'b0; t = 0; idx = 0;
        while (sb_q.size() > 0 && t < 4 * FRAME) begin
          @(negedge clk); t++;
          if (frame_start) begin on = 1'b1; fs_n++; end
          if (underflow) begin uf_n++; uf_at = idx; end
          if (on && vga_blank_n) begin
            want = sb_q.pop_front(); vectors++;
            if ({vga_r, vga_g, vga_b} !== want) begin miscompares++; $display("FAIL underflow_pixel %0d got %h want %h", idx, {vga_r, vga_g, vga_b}, want); end
            idx++;
          end
        end
        if (sb_q.size() > 0) begin vectors++; miscompares++; $display("FAIL underflow_drain got %0d left want 0", sb_q.size()); sb_q.delete(); end
      end
    join
    vectors++; if (uf_n !== 1) begin miscompares++; $display("FAIL underflow_pulses got %0d want 1", uf_n); end
    vectors++; if (uf_at !== K) begin miscompares++; $display("FAIL underflow_position got %0d want %0d", uf_at, K); end
    vectors++; if (fs_n !== 2) begin miscompares++; $display("FAIL underflow_starts got %0d want 2", fs_n); end
  endtask

  task automatic test_premature_sop();
    int uf_n, fs_n, uf_at;
    localparam int P = HA + 5;
    wait_vblank();
    push_ramp(24'h500000, P, NPIX);
    push_ramp(24'h600000, NPIX, NPIX);
    uf_n = 0; fs_n = 0; uf_at = -1;
    fork
      begin send_beats(24'h500000, P); send_beats(24'h600000, NPIX); end
      begin
        bit on; int t, idx; logic [23:0] want;
        on = 1'b0; t = 0; idx = 0;
        while (sb_q.size() > 0 && t < 4 * FRAME) begin
          @(negedge clk); t++;
          if (frame_start) begin on = 1'b1; fs_n++; end
          if (underflow) begin uf_n++; uf_at = idx; end
          if (on && vga_blank_n) begin
            want = sb_q.pop_front(); vectors++;
            if ({vga_r, vga_g, vga_b} !== want) begin miscompares++; $display("FAIL premature_pixel %0d got %h want %h", idx, {vga_r, vga_g, vga_b}, want); end
            idx++;
          end
        end
        if (sb_q.size() > 0) begin vectors++; miscompares++; $display("FAIL premature_drain got %0d left want 0", sb_q.size()); sb_q.delete(); end
      end
    join
    vectors++; if (uf_n !== 1) begin miscompares++; $display("FAIL premature_pulses got %0d want 1", uf_n); end
    vectors++; if (uf_at !== P) begin miscompares++; $display("FAIL premature_position got %0d want %0d", uf_at, P); end
    vectors++; if (fs_n !== 2) begin miscompares++; $display("FAIL premature_starts got %0d want 2", fs_n); end
  endtask

  task automatic test_lock_loss();
    int  n;
    bit  got;
    wait_vblank();
    send_beats(24'h700000, 2 * HA + 4);
    in_data = 24'hABCDEF;
    in_valid = 1'b1;
    in_sop = 1'b0;
    pll_locked = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lock_loss_early got in_ready=%b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (pins !== RST_PINS) begin miscompares++; $display("FAIL lock_loss_pins got %b want %b", pins, RST_PINS); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pll_locked = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 4 * LC) begin
      @(posedge clk); n++;
      @(negedge clk); got = in_ready;
    end
    vectors++;
    if (!got || n != LC + 2) begin miscompares++; $display("FAIL relock_latency got %0d cycles want %0d", n, LC + 2); end
  endtask

  task automatic test_rst_mid_frame();
    int  n;
    bit  got;
    wait_vblank();
    in_data = 24'h123456;
    in_valid = 1'b1;
    in_sop = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL pending_loaded got in_ready=%b want 0", in_ready); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (pins !== RST_PINS) begin miscompares++; $display("FAIL async_reset_pins got %b want %b", pins, RST_PINS); end
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 4 * LC) begin
      @(posedge clk); n++;
      @(negedge clk); got = in_ready;
    end
    vectors++;
    if (!got || n != LC + 2) begin miscompares++; $display("FAIL post_reset_latency got %0d cycles want %0d", n, LC + 2); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lock_filter();
    test_raster();
    test_full_frame();
    test_underflow();
    test_premature_sop();
    test_lock_loss();
    test_rst_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
